// File: rtl/alu_seq_pkg.sv
// Shared types and helpers for the multi-byte ALU sequencer and its byte-wide ALU.
package alu_seq_pkg;

  typedef enum logic [2:0] {
    OpAdd = 3'd0,
    OpSub = 3'd1,
    OpAnd = 3'd2,
    OpOr  = 3'd3,
    OpXor = 3'd4,
    OpShl = 3'd5,
    OpShr = 3'd6,
    OpNot = 3'd7
  } op_t;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StDone = 2'd2
  } state_t;

  localparam logic [2:0] AluNop = 3'b000;

  // Carry fed to the first byte; SUB forms two's complement with a forced carry-in.
  function automatic logic first_carry(input op_t op, input logic ci);
    logic c;
    case (op)
      OpAdd, OpShl, OpShr: c = ci;
      OpSub:               c = 1'b1;
      default:             c = 1'b0;
    endcase
    first_carry = c;
  endfunction

  function automatic logic is_logic_op(input op_t op);
    is_logic_op = (op == OpAnd) || (op == OpOr) || (op == OpXor) || (op == OpNot);
  endfunction

endpackage

// File: rtl/alu.sv
// Shared 8-bit combinational ALU; carry/shift chained through sc_i/sc_o.
module alu
  import alu_seq_pkg::*;
(
  input  logic [2:0] cmd,
  input  logic [7:0] inA,
  input  logic [7:0] inB,
  input  logic       sc_i,
  output logic [7:0] rslt,
  output logic       sc_o,
  output logic       zero,
  output logic       pari
);

  logic [8:0] sum;

  always_comb begin
    sum = '0;
    case (op_t'(cmd))
      OpAdd:   sum = {1'b0, inA} + {1'b0, inB} + {8'b0, sc_i};
      OpSub:   sum = {1'b0, inA} + {1'b0, ~inB} + 9'd1;
      OpAnd:   sum = {1'b0, inA & inB};
      OpOr:    sum = {1'b0, inA | inB};
      OpXor:   sum = {1'b0, inA ^ inB};
      OpShl:   sum = {inA, sc_i};
      OpShr:   sum = {inA[0], sc_i, inA[7:1]};
      OpNot:   sum = {1'b0, ~inA};
      default: sum = '0;
    endcase
  end

  assign rslt = sum[7:0];
  assign sc_o = sum[8];
  assign zero = (sum[7:0] == 8'h00);
  assign pari = ^sum[7:0];

endmodule

// File: rtl/alu_seq_map.sv
// Maps a multi-byte operation and the current byte index onto one 8-bit ALU command.
module alu_seq_map
  import alu_seq_pkg::*;
#(
  parameter int unsigned NBYTES = 2,
  parameter int unsigned IdxW   = (NBYTES > 1) ? $clog2(NBYTES) : 1
) (
  input  logic                  run_i,
  input  op_t                   op_i,
  input  logic [IdxW-1:0]       idx_i,
  input  logic                  carry_i,
  input  logic [8*NBYTES-1:0]   a_i,
  input  logic [8*NBYTES-1:0]   b_i,
  output logic [2:0]            cmd_o,
  output logic [7:0]            in_a_o,
  output logic [7:0]            in_b_o,
  output logic                  sc_in_o
);

  logic [7:0] a_byte;
  logic [7:0] b_byte;

  always_comb begin
    a_byte = '0;
    b_byte = '0;
    for (int k = 0; k < NBYTES; k++) begin
      if (idx_i == IdxW'(k)) begin
        a_byte = a_i[8*k +: 8];
        b_byte = b_i[8*k +: 8];
      end
    end
  end

  always_comb begin
    cmd_o   = AluNop;
    in_a_o  = '0;
    in_b_o  = '0;
    sc_in_o = 1'b0;
    if (run_i) begin
      in_a_o = a_byte;
      case (op_i)
        OpAdd: begin
          cmd_o   = OpAdd;
          in_b_o  = b_byte;
          sc_in_o = carry_i;
        end
        OpSub: begin
          cmd_o   = OpAdd;
          in_b_o  = ~b_byte;
          sc_in_o = carry_i;
        end
        OpAnd, OpOr, OpXor: begin
          cmd_o  = op_i;
          in_b_o = b_byte;
        end
        // NOT is realised as XOR with all-ones; the ALU NOT code is never issued.
        OpNot: begin
          cmd_o  = OpXor;
          in_b_o = 8'hFF;
        end
        OpShl, OpShr: begin
          cmd_o   = op_i;
          sc_in_o = carry_i;
        end
        default: cmd_o = AluNop;
      endcase
    end
  end

endmodule

// File: rtl/alu_byte_seq.sv
// Multi-byte ALU initiator: runs one NBYTES-wide operation through the shared 8-bit ALU
// a byte per cycle and returns the gathered result with carry, zero and parity.
module alu_byte_seq
  import alu_seq_pkg::*;
#(
  parameter int unsigned NBYTES = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [2:0]            req_op,
  input  logic [8*NBYTES-1:0]   req_a,
  input  logic [8*NBYTES-1:0]   req_b,
  input  logic                  req_ci,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [8*NBYTES-1:0]   rsp_rslt,
  output logic                  rsp_co,
  output logic                  rsp_zero,
  output logic                  rsp_pari,
  output logic [2:0]            alu_cmd,
  output logic [7:0]            alu_inA,
  output logic [7:0]            alu_inB,
  output logic                  alu_sc_i,
  input  logic [7:0]            alu_rslt,
  input  logic                  alu_sc_o
);

  localparam int unsigned W    = 8 * NBYTES;
  localparam int unsigned IdxW = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam logic [IdxW-1:0] IdxLast = IdxW'(NBYTES - 1);

  state_t          state_q, state_d;
  op_t             op_q, op_d;
  logic [W-1:0]    a_q, a_d;
  logic [W-1:0]    b_q, b_d;
  logic [IdxW-1:0] idx_q, idx_d;
  logic            carry_q, carry_d;
  logic [W-1:0]    result_q, result_d;

  logic is_shr;
  logic last_byte;

  assign is_shr    = (op_q == OpShr);
  assign last_byte = is_shr ? (idx_q == '0) : (idx_q == IdxLast);

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    a_d      = a_q;
    b_d      = b_q;
    idx_d    = idx_q;
    carry_d  = carry_q;
    result_d = result_q;
    case (state_q)
      StIdle: begin
        if (req_valid) begin
          op_d    = op_t'(req_op);
          a_d     = req_a;
          b_d     = req_b;
          carry_d = first_carry(op_t'(req_op), req_ci);
          idx_d   = (op_t'(req_op) == OpShr) ? IdxLast : '0;
          state_d = StRun;
        end
      end
      StRun: begin
        for (int k = 0; k < NBYTES; k++) begin
          if (idx_q == IdxW'(k)) result_d[8*k +: 8] = alu_rslt;
        end
        carry_d = is_logic_op(op_q) ? 1'b0 : alu_sc_o;
        if (last_byte) begin
          state_d = StDone;
        end else begin
          idx_d = is_shr ? idx_q - IdxW'(1) : idx_q + IdxW'(1);
        end
      end
      StDone: begin
        if (rsp_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= StIdle;
      op_q     <= OpAdd;
      a_q      <= '0;
      b_q      <= '0;
      idx_q    <= '0;
      carry_q  <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      a_q      <= a_d;
      b_q      <= b_d;
      idx_q    <= idx_d;
      carry_q  <= carry_d;
      result_q <= result_d;
    end
  end

  alu_seq_map #(
    .NBYTES (NBYTES),
    .IdxW   (IdxW)
  ) u_map (
    .run_i   (state_q == StRun),
    .op_i    (op_q),
    .idx_i   (idx_q),
    .carry_i (carry_q),
    .a_i     (a_q),
    .b_i     (b_q),
    .cmd_o   (alu_cmd),
    .in_a_o  (alu_inA),
    .in_b_o  (alu_inB),
    .sc_in_o (alu_sc_i)
  );

  assign req_ready = (state_q == StIdle);
  assign rsp_valid = (state_q == StDone);
  assign rsp_rslt  = result_q;
  assign rsp_co    = carry_q;
  assign rsp_zero  = (result_q == '0);
  assign rsp_pari  = ^result_q;

endmodule

// File: tb/tb_alu_byte_seq.sv
// Scoreboard bench for alu_byte_seq (NBYTES=2) driving the real byte ALU.
module tb_alu_byte_seq;
  import alu_seq_pkg::*;

  typedef struct packed {
    logic [15:0] rslt;
    logic        co;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_ready;
  logic [2:0]  req_op;
  logic [15:0] req_a, req_b;
  logic        req_ci;
  logic        rsp_valid, rsp_ready;
  logic [15:0] rsp_rslt;
  logic        rsp_co, rsp_zero, rsp_pari;
  logic [2:0]  alu_cmd;
  logic [7:0]  alu_inA, alu_inB, alu_rslt;
  logic        alu_sc_i, alu_sc_o, alu_zero, alu_pari;

  int   n_cmp = 0;
  int   n_err = 0;
  exp_t sb_q[$];

  always #5 clk = ~clk;

  alu_byte_seq #(.NBYTES(2)) u_dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_op    (req_op),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_ci    (req_ci),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_rslt  (rsp_rslt),
    .rsp_co    (rsp_co),
    .rsp_zero  (rsp_zero),
    .rsp_pari  (rsp_pari),
    .alu_cmd   (alu_cmd),
    .alu_inA   (alu_inA),
    .alu_inB   (alu_inB),
    .alu_sc_i  (alu_sc_i),
    .alu_rslt  (alu_rslt),
    .alu_sc_o  (alu_sc_o)
  );

  alu u_alu (
    .cmd  (alu_cmd),
    .inA  (alu_inA),
    .inB  (alu_inB),
    .sc_i (alu_sc_i),
    .rslt (alu_rslt),
    .sc_o (alu_sc_o),
    .zero (alu_zero),
    .pari (alu_pari)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Independent 16-bit reference of the full-width operation.
  function automatic exp_t model(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b,
                                 input logic ci);
    logic [16:0] s;
    exp_t        e;
    case (op)
      3'd0:    s = {1'b0, a} + {1'b0, b} + {16'b0, ci};
      3'd1:    s = {1'b0, a} + {1'b0, ~b} + 17'd1;
      3'd2:    s = {1'b0, a & b};
      3'd3:    s = {1'b0, a | b};
      3'd4:    s = {1'b0, a ^ b};
      3'd5:    s = {a, ci};
      3'd6:    s = {a[0], ci, a[15:1]};
      default: s = {1'b0, ~a};
    endcase
    e.rslt = s[15:0];
    e.co   = s[16];
    return e;
  endfunction

  task automatic run_op(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b,
                        input logic ci, input int hold, input exp_t e);
    int         lat;
    exp_t       got;
    logic [7:0] exp_b0, exp_b1;
    logic [2:0] exp_cmd;
    exp_b0  = (op == OpShr) ? a[15:8] : a[7:0];
    exp_b1  = (op == OpShr) ? a[7:0] : a[15:8];
    exp_cmd = (op == OpSub) ? 3'd0 : (op == OpNot) ? 3'd4 : op;
    sb_q.push_back(e);
    @(negedge clk);
    check_eq("req_ready_idle", {31'b0, req_ready}, 32'd1);
    req_valid = 1'b1;
    req_op    = op;
    req_a     = a;
    req_b     = b;
    req_ci    = ci;
    @(posedge clk);
    #1 req_valid = 1'b0;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
      if (lat == 1) begin
        check_eq("alu_byte0", {24'b0, alu_inA}, {24'b0, exp_b0});
        check_eq("alu_cmd", {29'b0, alu_cmd}, {29'b0, exp_cmd});
      end
      if (lat == 2) check_eq("alu_byte1", {24'b0, alu_inA}, {24'b0, exp_b1});
    end while (!rsp_valid && lat < 10);
    check_eq("latency", lat, 32'd3);
    got = sb_q.pop_front();
    check_eq("rslt", {16'b0, rsp_rslt}, {16'b0, got.rslt});
    check_eq("co", {31'b0, rsp_co}, {31'b0, got.co});
    check_eq("zero", {31'b0, rsp_zero}, {31'b0, (got.rslt == 16'h0)});
    check_eq("pari", {31'b0, rsp_pari}, {31'b0, ^got.rslt});
    for (int i = 0; i < hold; i++) begin
      req_valid = 1'b1;
      req_op    = OpOr;
      req_a     = 16'hAAAA;
      req_b     = 16'h5555;
      @(negedge clk);
      check_eq("hold_valid", {31'b0, rsp_valid}, 32'd1);
      check_eq("hold_rslt", {16'b0, rsp_rslt}, {16'b0, got.rslt});
      check_eq("hold_co", {31'b0, rsp_co}, {31'b0, got.co});
      check_eq("hold_req_ready", {31'b0, req_ready}, 32'd0);
      check_eq("hold_alu_idle", {21'b0, alu_cmd, alu_inA}, 32'd0);
    end
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    rsp_ready = 1'b0;
    req_valid = 1'b0;
    @(negedge clk);
    check_eq("post_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    check_eq("post_req_ready", {31'b0, req_ready}, 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [2:0]  op;
    logic [15:0] a, b;
    logic        ci;
    reset     = 1'b1;
    req_valid = 1'b0;
    req_op    = '0;
    req_a     = '0;
    req_b     = '0;
    req_ci    = 1'b0;
    rsp_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("rst_req_ready", {31'b0, req_ready}, 32'd1);
    check_eq("rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    check_eq("rst_rslt", {16'b0, rsp_rslt}, 32'd0);
    check_eq("rst_flags", {29'b0, rsp_co, rsp_zero, rsp_pari}, 32'b010);
    check_eq("rst_alu", {20'b0, alu_cmd, alu_inA, alu_sc_i}, 32'd0);
    reset = 1'b0;

    run_op(OpAdd, 16'hFFFF, 16'h0001, 1'b0, 0, '{rslt: 16'h0000, co: 1'b1});
    run_op(OpSub, 16'h0000, 16'h0001, 1'b1, 0, '{rslt: 16'hFFFF, co: 1'b0});
    run_op(OpSub, 16'h0100, 16'h0001, 1'b0, 0, '{rslt: 16'h00FF, co: 1'b1});
    run_op(OpShl, 16'h8001, 16'h1234, 1'b1, 0, '{rslt: 16'h0003, co: 1'b1});
    run_op(OpShr, 16'h0180, 16'h0000, 1'b0, 0, '{rslt: 16'h00C0, co: 1'b0});
    run_op(OpNot, 16'h00F0, 16'h5A5A, 1'b1, 0, '{rslt: 16'hFF0F, co: 1'b0});
    run_op(OpAnd, 16'h0F0F, 16'h00FF, 1'b1, 5, '{rslt: 16'h000F, co: 1'b0});

    // Reset during the second RUN cycle discards the partial result.
    @(negedge clk);
    req_valid = 1'b1;
    req_op    = OpAdd;
    req_a     = 16'h1234;
    req_b     = 16'h0101;
    req_ci    = 1'b0;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check_eq("mid_run_byte1", {24'b0, alu_inA}, 32'h12);
    reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check_eq("mid_rst_req_ready", {31'b0, req_ready}, 32'd1);
    check_eq("mid_rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    check_eq("mid_rst_rslt", {16'b0, rsp_rslt}, 32'd0);
    check_eq("mid_rst_zero", {31'b0, rsp_zero}, 32'd1);
    run_op(OpAdd, 16'h1234, 16'h0101, 1'b1, 0, '{rslt: 16'h1336, co: 1'b0});

    for (int i = 0; i < 10; i++) begin
      op = 3'($urandom_range(0, 7));
      a  = 16'($urandom);
      b  = 16'($urandom);
      ci = 1'($urandom);
      run_op(op, a, b, ci, int'($urandom_range(0, 2)), model(op, a, b, ci));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
